// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, the bridge state encoding,
// and a helper that classifies a response as an error.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WAIT_B       = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_WAIT_R       = 3'd4,
        ST_RESP         = 3'd5
    } axi_mst_state_t;

    // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding core load/store to AXI-Lite master bridge.
// One request is registered at a time; completion is a one-cycle rsp_valid
// pulse carrying read data (held from the last read) and an error flag.
// AXI_DATA_WIDTH is expected to be 32.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int         AXI_DATA_WIDTH = 32,
    parameter int         AXI_ADDR_WIDTH = 4,
    parameter logic [2:0] PROT           = 3'b000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    axi_lite_if.master                  axi
);

    axi_mst_state_t              state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;

    logic req_hs;
    logic aw_hs;
    logic w_hs;

    assign req_hs = req_valid & req_ready;
    assign aw_hs  = axi.AWVALID & axi.AWREADY;
    assign w_hs   = axi.WVALID & axi.WREADY;

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: request capture, AW/W completion tracking, response capture.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR_DATA: begin
                // AW and W finish independently; leave once both have handshaken.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (axi.BVALID) begin
                    err_d   = resp_is_err(axi.BRESP);
                    state_d = ST_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (axi.ARREADY) state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (axi.RVALID) begin
                    rdata_d = axi.RDATA;
                    err_d   = resp_is_err(axi.RRESP);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so no VALID depends on an input.
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        rsp_valid   = (state_q == ST_RESP);
        rsp_rdata   = rdata_q;
        rsp_err     = err_q;
        axi.AWADDR  = addr_q;
        axi.AWPROT  = PROT;
        axi.AWVALID = (state_q == ST_WR_ADDR_DATA) && !aw_done_q;
        axi.WDATA   = wdata_q;
        axi.WSTRB   = wstrb_q;
        axi.WVALID  = (state_q == ST_WR_ADDR_DATA) && !w_done_q;
        axi.BREADY  = (state_q == ST_WAIT_B);
        axi.ARADDR  = addr_q;
        axi.ARPROT  = PROT;
        axi.ARVALID = (state_q == ST_RD_ADDR);
        axi.RREADY  = (state_q == ST_WAIT_R);
    end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
Converts the core's single-outstanding load/store request into AXI-Lite master transactions on an axi_lite_if bundle. Sits directly upstream of the AXI-Lite interface and drives its master-side signals. Carries one transaction at a time, registers the request fields, and returns a one-cycle response pulse with read data and an error flag.

Parameters:
AXI_DATA_WIDTH, 32, data width, must be 32
AXI_ADDR_WIDTH, 4, AXI address width; req_addr is the same width
PROT, 3'b000, constant driven on AWPROT/ARPROT

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  core request present
req_ready  out  1  bridge idle, accepts request
req_we  in  1  1=write, 0=read
req_addr  in  AXI_ADDR_WIDTH  byte address
req_wdata  in  AXI_DATA_WIDTH  write data
req_wstrb  in  AXI_DATA_WIDTH/8  byte enables
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  AXI_DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  RESP[1] of completing transfer
AWADDR/AWPROT/AWVALID  out  ADDR/3/1  write address channel
AWREADY  in  1
WDATA/WSTRB/WVALID  out  DATA/DATA/8/1  write data channel
WREADY  in  1
BRESP/BVALID  in  2/1; BREADY  out  1  write response channel
ARADDR/ARPROT/ARVALID  out  ADDR/3/1  read address channel
ARREADY  in  1
RDATA/RRESP/RVALID  in  DATA/2/1; RREADY  out  1  read data channel

Behaviour:
- Reset: state=IDLE; all VALID/READY outputs, rsp_valid, rsp_err = 0; rsp_rdata, AWADDR, ARADDR, WDATA = 0; WSTRB = 0.
- Reset mid-transaction aborts immediately. All VALIDs are low the cycle after the reset edge. No response pulse is issued.
- req_ready = (state==IDLE). Handshake = req_valid & req_ready; addr, wdata, wstrb and we are registered on it.
- States: IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RESP.
- IDLE --write--> WR_ADDR_DATA:
  - AWVALID and WVALID rise together in the next cycle.
  - Each VALID drops in the cycle after its own READY handshake. Flags aw_done and w_done track completion.
  - AW and W may complete in either order or in the same cycle. VALID is never withdrawn before its handshake.
  - When both are done -> WAIT_B.
- WAIT_B: BREADY=1. On BVALID, capture BRESP -> RESP.
- IDLE --read--> RD_ADDR: ARVALID=1 until ARREADY -> WAIT_R.
- WAIT_R: RREADY=1. On RVALID, capture RDATA and RRESP -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata holds the last read data; it is unchanged by writes.
  - rsp_err = captured resp[1] (SLVERR/DECERR=1, OKAY/EXOKAY=0).
- BREADY/RREADY are never asserted outside their wait states. AWVALID, WVALID and ARVALID are never high simultaneously with a read/write of the other kind.
- Minimum latency: request accepted at cycle 0, rsp_valid at cycle 3, for zero-wait slaves (read and write).
- wstrb=0 writes are issued unchanged. Address alignment is not checked.
- Core must not depend on req_ready during RESP. A new request can be accepted the cycle after rsp_valid.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - state enum axi_mst_state_t
- Single module, no sub-module. Bench connects the AXI ports to axi_lite_if with matching widths.

Test Plan:
- Write addr=4'h8, wdata=32'hDEADBEEF, wstrb=4'hF, slave all-ready, BRESP=OKAY -> AW/W handshake at cycle 1, rsp_valid at cycle 3, rsp_err=0, slave stores DEADBEEF.
- Read addr=4'h4, slave returns RDATA=32'h12345678 with 2 wait cycles on ARREADY and 3 on RVALID -> ARVALID held stable, rsp_valid once with rsp_rdata=12345678.
- Write with WREADY 4 cycles before AWREADY, then repeated with reversed order and with both same-cycle -> each VALID drops right after its own handshake, exactly one B accepted, one rsp_valid each.
- Read returning RRESP=SLVERR and write returning BRESP=DECERR -> rsp_err=1 for both; rsp_rdata updated only by the read.
- reset asserted during WAIT_R, then deasserted; RVALID stays low -> all outputs at reset values next cycle, no rsp_valid, req_ready=1 afterward.
- Back-to-back: req_valid held high across 5 alternating read/write requests -> at most one transaction outstanding, req_ready low except in IDLE, 5 rsp pulses in order.
